// File: rtl/alert_quarantine_logger_if.sv
// Alert input, host readout and host clear bundle for the alert quarantine logger.
interface alert_quarantine_logger_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
);
    logic                       alert_valid;
    logic [1:0]                 alert_module_id;
    logic [3:0]                 alert_addr;
    logic [3:0]                 alert_data;
    logic                       rd_valid;
    logic                       rd_ready;
    logic [1:0]                 rd_module_id;
    logic [3:0]                 rd_addr;
    logic [3:0]                 rd_data;
    logic [$clog2(DEPTH):0]     fifo_count;
    logic                       overflow;
    logic [CNT_W-1:0]           drop_count;
    logic [3:0]                 quarantine;
    logic                       clear_valid;
    logic [1:0]                 clear_id;
    logic                       clear_all;
    logic                       lockdown;
    logic [1:0]                 state;

    modport slave (
        input  alert_valid, alert_module_id, alert_addr, alert_data,
        input  rd_ready, clear_valid, clear_id, clear_all,
        output rd_valid, rd_module_id, rd_addr, rd_data, fifo_count,
        output overflow, drop_count, quarantine, lockdown, state
    );

    modport master (
        output alert_valid, alert_module_id, alert_addr, alert_data,
        output rd_ready, clear_valid, clear_id, clear_all,
        input  rd_valid, rd_module_id, rd_addr, rd_data, fifo_count,
        input  overflow, drop_count, quarantine, lockdown, state
    );
endinterface

// File: rtl/alert_quarantine_logger.sv
// Logs write-monitor alerts into a small FIFO, counts violations per module,
// quarantines repeat offenders and escalates to lockdown.
module alert_quarantine_logger #(
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 4,
    parameter int THRESHOLD = 3,
    parameter int LOCK_MIN  = 2
) (
    input logic clk,
    input logic rst,
    alert_quarantine_logger_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [1:0] id;
        logic [3:0] addr;
        logic [3:0] data;
    } alertRec_t;

    typedef enum logic [1:0] {IDLE = 2'd0, LOGGING = 2'd1, LOCKDOWN = 2'd2} state_t;

    alertRec_t        mem [DEPTH];
    alertRec_t        inRec, headNext;
    logic [PW-1:0]    wrPtr, rdPtr, rdPtrNext;
    logic [CW-1:0]    count, countNext;
    logic             full, pop, push, drop, clrAll;
    logic [3:0][CNT_W-1:0] cnt, cntNext;
    logic [3:0]       qNext;
    logic [CNT_W-1:0] dropNext;
    logic             ovfNext, lockHit;
    state_t           state, stateNext;

    assign inRec  = '{id: bus.alert_module_id, addr: bus.alert_addr, data: bus.alert_data};
    assign full   = (count == CW'(DEPTH));
    assign pop    = (count != '0) && bus.rd_ready;
    assign push   = bus.alert_valid && (!full || pop);
    assign drop   = bus.alert_valid && full && !pop;
    assign clrAll = bus.clear_valid && bus.clear_all;

    always_comb begin
        countNext = count;
        if (push && !pop)      countNext = count + 1'b1;
        else if (pop && !push) countNext = count - 1'b1;
        rdPtrNext = pop ? rdPtr + 1'b1 : rdPtr;
        // The head slot may be the one being written this very edge.
        headNext  = (push && wrPtr == rdPtrNext) ? inRec : mem[rdPtrNext];
    end

    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= inRec;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wrPtr            <= '0;
            rdPtr            <= '0;
            count            <= '0;
            bus.rd_valid     <= 1'b0;
            bus.rd_module_id <= '0;
            bus.rd_addr      <= '0;
            bus.rd_data      <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            rdPtr            <= rdPtrNext;
            count            <= countNext;
            bus.rd_valid     <= (countNext != '0);
            bus.rd_module_id <= (countNext != '0) ? headNext.id   : '0;
            bus.rd_addr      <= (countNext != '0) ? headNext.addr : '0;
            bus.rd_data      <= (countNext != '0) ? headNext.data : '0;
        end
    end

    assign bus.fifo_count = count;

    // A clear beats a same-cycle alert for that module; the alert is still logged.
    always_comb begin
        for (int m = 0; m < 4; m++) begin
            cntNext[m] = cnt[m];
            qNext[m]   = bus.quarantine[m];
            if (bus.clear_valid && (bus.clear_all || bus.clear_id == 2'(m))) begin
                cntNext[m] = '0;
                qNext[m]   = 1'b0;
            end else if (bus.alert_valid && bus.alert_module_id == 2'(m)) begin
                if (cnt[m] != '1) cntNext[m] = cnt[m] + 1'b1;
                if (cntNext[m] >= CNT_W'(THRESHOLD)) qNext[m] = 1'b1;
            end
        end
        ovfNext  = bus.overflow;
        dropNext = bus.drop_count;
        if (clrAll) begin
            ovfNext  = 1'b0;
            dropNext = '0;
        end else if (drop) begin
            ovfNext = 1'b1;
            if (bus.drop_count != '1) dropNext = bus.drop_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt            <= '0;
            bus.quarantine <= '0;
            bus.overflow   <= 1'b0;
            bus.drop_count <= '0;
        end else begin
            cnt            <= cntNext;
            bus.quarantine <= qNext;
            bus.overflow   <= ovfNext;
            bus.drop_count <= dropNext;
        end
    end

    assign lockHit = ($countones(qNext) >= LOCK_MIN);

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (bus.alert_valid) stateNext = lockHit ? LOCKDOWN : LOGGING;
            end
            LOGGING: begin
                if (lockHit)                                stateNext = LOCKDOWN;
                else if (countNext == '0 && qNext == '0)    stateNext = IDLE;
            end
            LOCKDOWN: begin
                if (clrAll) stateNext = (countNext == '0) ? IDLE : LOGGING;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            bus.lockdown <= 1'b0;
        end else begin
            state        <= stateNext;
            bus.lockdown <= (stateNext == LOCKDOWN);
        end
    end

    assign bus.state = state;
endmodule

// File: doc/alert_quarantine_logger.md
Name: alert_quarantine_logger

Overview:
- Downstream consumer of the memory write monitor's alert outputs; one alert event per cycle with alert_valid high.
- Buffers each alert record {module ID, address, data} in a small FIFO for host readout via valid/ready.
- Keeps saturating per-module violation counters and quarantines a module once it reaches THRESHOLD.
- Escalates to a global lockdown when too many modules are quarantined.

Parameters:
- DEPTH, 4, FIFO entries; must be a power of two ≥ 2.
- CNT_W, 4, width of each per-module violation counter and of drop_count.
- THRESHOLD, 3, violation count at which a module is quarantined; range 1 to 2^CNT_W−1.
- LOCK_MIN, 2, number of quarantined modules that forces LOCKDOWN; range 1 to 4.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- alert_valid  in  1  one alert event this cycle (driven by upstream alertValid).
- alert_module_id  in  2  offending module ID.
- alert_addr  in  4  offending write address.
- alert_data  in  4  offending write data.
- rd_valid  out  1  FIFO head valid.
- rd_ready  in  1  host consumes head when rd_valid & rd_ready.
- rd_module_id  out  2  head record ID.
- rd_addr  out  4  head record address.
- rd_data  out  4  head record data.
- fifo_count  out  log2(DEPTH)+1  entries held.
- overflow  out  1  sticky: an alert was dropped.
- drop_count  out  CNT_W  saturating count of dropped alerts.
- quarantine  out  4  bit n set = module n quarantined (sticky).
- clear_valid  in  1  host clear request (single-cycle pulse).
- clear_id  in  2  module to un-quarantine.
- clear_all  in  1  with clear_valid: clear all modules, overflow, drop_count, and exit LOCKDOWN.
- lockdown  out  1  high in LOCKDOWN state.
- state  out  2  FSM state: 0 IDLE, 1 LOGGING, 2 LOCKDOWN.

Behaviour:
- Reset (rst=0 at clk edge):
  - FIFO emptied; rd_valid=0; rd_* = 0; fifo_count=0.
  - overflow=0; drop_count=0; quarantine=0; all counters 0.
  - lockdown=0; state=IDLE.
  - Reset mid-operation discards all contents; no partial pop.
- FIFO:
  - Push when alert_valid.
  - Pop when rd_valid & rd_ready.
  - rd_* are registered head outputs; the first entry is visible one cycle after its push.
  - Pointers wrap modulo DEPTH.
  - Full with no pop: alert dropped, overflow←1, drop_count+1 saturating at all-ones.
  - Full with simultaneous pop: push accepted, count unchanged, no drop.
  - Empty: pop ignored.
- Counters: each alert (logged or dropped) increments cnt[alert_module_id], saturating.
- Quarantine set: quarantine[id] is set on the same edge the counter's next value ≥ THRESHOLD.
- clear_valid (per-module clear):
  - cnt[clear_id]←0 and quarantine[clear_id]←0.
  - Clear has priority over a same-cycle alert for that module: counter ends at 0, but the alert is still logged.
- clear_valid & clear_all: all counters, quarantine, overflow and drop_count cleared. FIFO contents are untouched.
- FSM, evaluated on registered state and next-cycle values:
  - IDLE→LOGGING: alert_valid.
  - LOGGING→IDLE: FIFO empty and quarantine==0 after the update.
  - LOGGING→LOCKDOWN: popcount(next quarantine) ≥ LOCK_MIN.
  - LOCKDOWN→IDLE or LOGGING: only on clear_valid & clear_all; IDLE if the FIFO will be empty, else LOGGING.
  - Per-module clears do not exit LOCKDOWN.
  - In LOCKDOWN, alerts are still logged and counted.
- lockdown = (state==LOCKDOWN), registered.

Test Plan:
- Reset, then push id=1/addr=0xA/data=0x3 with rd_ready=0 → next cycle rd_valid=1, rd_module_id=1, rd_addr=0xA, rd_data=3, fifo_count=1, state=LOGGING.
- 5 consecutive alerts, rd_ready=0 → fifo_count=4, 5th dropped, overflow=1, drop_count=1; with rd_ready=1 and an alert in the same cycle while full → count stays 4, drop_count stays 1.
- 3 alerts from id=2 → quarantine=4'b0100 on the 3rd edge; clear_valid with clear_id=2 in the same cycle as a 4th id=2 alert → quarantine=0, alert present in FIFO.
- 3 alerts each from ids 0 and 3 → quarantine=4'b1001, lockdown=1, state=2; per-module clear of id 0 → lockdown stays 1; clear_all → quarantine=0, overflow=0, state=LOGGING while the FIFO is non-empty.
- Drain the FIFO with rd_ready=1 and no quarantine → state returns to IDLE, rd_valid=0.
- Assert rst=0 mid-drain with 3 entries → next cycle fifo_count=0, rd_valid=0, state=IDLE, all counters 0.
